// File: rtl/spi_slave_rx_if.sv
// Bundle of SPI lines, receive stream and status/flag signals for spi_slave_rx.
interface spi_slave_rx_if;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic       clr_flags;

    modport slave (
        input  sck, cs_n, mosi, rx_ready, clr_flags,
        output rx_data, rx_valid, busy, overrun, frame_err
    );

    modport master (
        output sck, cs_n, mosi, rx_ready, clr_flags,
        input  rx_data, rx_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive endpoint: synchronizes sck/cs_n/mosi, assembles MSB-first bytes.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_rx_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_slave_rx: SYNC_STAGES must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_slave_rx: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   cs_rise;
    logic                   cs_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    // Only the 7 bits that precede the incoming bit are ever read, so the MSB is not stored.
    logic [6:0] shift;
    logic [2:0] cnt_after;
    logic       push;
    logic [7:0] push_data;
    logic       partial;
    logic       pop;
    logic       drop;

    always_comb begin
        cnt_after = sck_rise ? bit_cnt + 3'd1 : bit_cnt;
        push      = (state == RECV) && sck_rise && (bit_cnt == 3'd7);
        push_data = {shift, mosi_s};
        partial   = (state == RECV) && cs_rise && (cnt_after != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (sck_rise) begin
                        shift   <= {shift[5:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RECV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.overrun   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.overrun   <= drop | (bus.overrun & ~bus.clr_flags);
            bus.frame_err <= partial | (bus.frame_err & ~bus.clr_flags);
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        wr_en;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = ~empty & bus.rx_ready;
        // When full, a same-cycle pop frees the slot the write pointer is aiming at.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign bus.rx_valid = ~empty;
    assign bus.rx_data  = mem[rd_ptr[AW-1:0]];
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    always_comb begin
        pop  = hold_valid & bus.rx_ready;
        drop = push & hold_valid & ~pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push && (!hold_valid || pop)) begin
            hold_data  <= push_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign bus.rx_valid = hold_valid;
    assign bus.rx_data  = hold_data;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed + randomized bench for spi_slave_rx; model is a bounded queue of expected bytes.
module tb_spi_slave_rx;
    localparam int S = 2;
`ifdef SPI_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_rx_if bus();

    spi_slave_rx #(.SYNC_STAGES(S), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < CAP) mq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic spi_bit_rise(input logic b);
        @(negedge clk) bus.mosi = b;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.sck = 1'b1;
    endtask

    task automatic spi_bit(input logic b);
        spi_bit_rise(b);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.sck = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) spi_bit(b[7-i]);
        if (n == 8) model_push(b);
    endtask

    task automatic start_frame();
        @(negedge clk) bus.cs_n = 1'b0;
        @(posedge clk) #1 check("busy_pre", bus.busy, 8'd0);
        repeat (S + 1) @(posedge clk);
        #1 check("busy_on", bus.busy, 8'd1);
    endtask

    task automatic end_frame();
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        @(posedge clk) #1 check("busy_hold", bus.busy, 8'd1);
        repeat (S + 1) @(posedge clk);
        #1 check("busy_off", bus.busy, 8'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovr"}, bus.overrun, {7'd0, m_ovr});
        check({tag, "_ferr"}, bus.frame_err, {7'd0, m_ferr});
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            check({tag, "_valid"}, bus.rx_valid, 8'd1);
            check({tag, "_data"}, bus.rx_data, mq[0]);
            @(negedge clk) bus.rx_ready = 1'b1;
            @(negedge clk) bus.rx_ready = 1'b0;
            void'(mq.pop_front());
        end
        check({tag, "_empty"}, bus.rx_valid, 8'd0);
    endtask

    task automatic clear_flags();
        @(negedge clk) bus.clr_flags = 1'b1;
        @(negedge clk) bus.clr_flags = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        check_flags("clr");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] b;

        rst = 1'b1;
        bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.rx_ready = 1'b0; bus.clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", bus.rx_data, 8'h00);
        check("rst_valid", bus.rx_valid, 8'd0);
        check("rst_busy", bus.busy, 8'd0);
        check_flags("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5 with rx_ready=1: latency is S edges after the edge capturing the 8th sck rise
        bus.rx_ready = 1'b1;
        start_frame();
        send_bits(8'hA5, 7);
        spi_bit_rise(1'b1);
        for (int j = 1; j <= S + 1; j++) begin
            @(posedge clk) #1;
            if (j == S) check("lat_early", bus.rx_valid, 8'd0);
        end
        check("lat_valid", bus.rx_valid, 8'd1);
        check("lat_data", bus.rx_data, 8'hA5);
        @(posedge clk) #1 check("lat_pulse", bus.rx_valid, 8'd0);
        @(negedge clk) bus.sck = 1'b0;
        end_frame();
        bus.rx_ready = 1'b0;
        check_flags("a5");

        // two bytes, no consumer
        start_frame();
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        end_frame();
        check_flags("two");
        drain("two");
        clear_flags();

        // truncated frame, then a clean one
        start_frame();
        send_bits(8'hB7, 5);
        end_frame();
        m_ferr = 1'b1;
        check_flags("trunc");
        check("trunc_valid", bus.rx_valid, 8'd0);
        start_frame();
        send_bits(8'h81, 8);
        end_frame();
        check_flags("after_trunc");
        drain("b81");
        clear_flags();

        // second byte completes in the same cycle the first is popped
        start_frame();
        send_bits(8'h11, 8);
        send_bits(8'h22, 7);
        spi_bit_rise(1'b0);
        repeat (S) @(negedge clk);
        check("simul_head", bus.rx_data, 8'h11);
        bus.rx_ready = 1'b1;
        @(negedge clk) bus.rx_ready = 1'b0;
        void'(mq.pop_front());
        model_push(8'h22);
        bus.sck = 1'b0;
        end_frame();
        check_flags("simul");
        drain("simul");

        // reset in the middle of a byte
        start_frame();
        send_bits(8'h55, 8);
        send_bits(8'hF0, 4);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_data", bus.rx_data, 8'h00);
        check("mid_rst_valid", bus.rx_valid, 8'd0);
        check("mid_rst_busy", bus.busy, 8'd0);
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check_flags("mid_rst");
        bus.cs_n = 1'b1;
        bus.sck  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (S + 2) @(negedge clk);
        start_frame();
        send_bits(8'h0F, 8);
        end_frame();
        check_flags("post_rst");
        drain("b0f");

        // five bytes with the consumer stalled
        start_frame();
        for (int k = 1; k <= 5; k++) send_bits(8'(k), 8);
        end_frame();
        check_flags("five");
        drain("five");
        clear_flags();

        // random frames; first one is six bytes to wrap the pointers
        for (int it = 0; it < 8; it++) begin
            n = (it == 0) ? 6 : $urandom_range(1, CAP + 2);
            start_frame();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_bits(b, 8);
            end
            if ($urandom_range(0, 2) == 0) begin
                send_bits(8'($urandom), $urandom_range(1, 7));
                m_ferr = 1'b1;
            end
            end_frame();
            check_flags("rnd");
            drain("rnd");
            clear_flags();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side SPI endpoint (mode 0, MSB first, 8-bit bytes) that consumes the sck/cs_n/mosi lines driven by the team's SPI master.
- Samples the SPI lines in the system clock domain, assembles bytes and presents them on a valid/ready stream interface.
- Flags overrun and truncated frames.
- Serves as the loopback/peer block for link bring-up and the downstream consumer in the SPI test path.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer (minimum 2).
- FIFO_DEPTH, 4, receive FIFO entries, power of 2; used only when SPI_RX_FIFO_EN is defined.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- sck  input  1  SPI clock from master; idle low.
- cs_n  input  1  chip select, active low.
- mosi  input  1  serial data from master.
- rx_data  output  8  received byte at head of buffer.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- busy  output  1  frame in progress (state RECV).
- overrun  output  1  sticky: a completed byte was dropped because the buffer was full.
- frame_err  output  1  sticky: cs_n deasserted with a partial byte.
- clr_flags  input  1  single-cycle pulse; clears overrun and frame_err.

Behaviour:
- Reset (async, rst=1): state IDLE, bit_cnt=0, shift=0, buffer empty; rx_data=0x00, rx_valid=0, busy=0, overrun=0, frame_err=0. Synchronizer flops reset to sck=0, cs_n=1, mosi=0. Applies immediately, including mid-byte; any partial byte is discarded.
- Synchronization: sck, cs_n and mosi each pass through SYNC_STAGES flops, so all three carry equal delay. An extra flop on synced sck and cs_n provides edge detection (rise/fall).
- Input timing: sck high and low phases are each at least 1 clk, which is the master's rate; no faster input is supported.
- FSM IDLE:
  - busy=0.
  - On synced cs_n falling: go to RECV, bit_cnt<=0.
- FSM RECV:
  - busy=1.
  - On synced sck rising: shift<={shift[6:0],mosi_s}, bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
  - When bit_cnt==7 at that rising edge, the byte {shift[6:0],mosi_s} completes and is pushed to the buffer in the same clk edge. The FSM stays in RECV, so multi-byte frames are supported.
  - On synced cs_n rising: go to IDLE. If bit_cnt!=0, frame_err<=1 and the partial byte is dropped.
  - A sck rise and a cs_n rise in the same cycle: the sck rise is processed first (it may complete a byte), then frame end is evaluated on the updated bit_cnt.
- Latency: rx_valid asserts exactly SYNC_STAGES clk edges after the clk edge that first captures raw sck=1 for the 8th bit.
- Buffer (without FIFO): single holding register.
  - rx_valid=1 while full.
  - Pop when rx_valid && rx_ready.
- Push while full:
  - Simultaneous pop in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
  - No pop: new byte dropped, old byte kept, overrun<=1.
- rx_data holds its value while rx_valid=0.
- Sticky flags: overrun and frame_err clear only on clr_flags or rst. If clr_flags and a new set event occur in the same cycle, the set wins.
- sck edges while in IDLE are ignored.

Optional Feature:
- Macro: SPI_RX_FIFO_EN.
- Defined: the holding register is replaced by a FIFO_DEPTH-entry circular FIFO.
  - Read/write pointers are one bit wider than log2(FIFO_DEPTH) for full/empty detection.
  - rx_data = head entry (first-word fall-through); rx_valid = not empty.
  - Overrun only when the FIFO is full and there is no same-cycle pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: single holding register as described above; FIFO_DEPTH is ignored.

Test Plan:
- Single-byte frame, master sends 0xA5, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5. Latency matches SYNC_STAGES. busy is high only between synced cs_n edges.
- Two-byte frame 0x3C,0xC3, rx_ready held 0:
  - No FIFO: rx_data=0x3C, overrun=1.
  - With FIFO: two entries, 0x3C then 0xC3, overrun=0.
- cs_n raised after 5 sck rises -> frame_err=1, no rx_valid. The next full frame 0x81 is received correctly; clr_flags then clears frame_err.
- Buffer full with 0x11, and the second byte 0x22 completes in the same cycle that rx_ready=1 -> 0x11 popped, 0x22 presented, overrun=0.
- rst asserted after 4 bits of 0xF0 -> all outputs reach reset values immediately. After release, frame 0x0F -> rx_data=0x0F.
- FIFO build only: 5 bytes 0x01..0x05 with rx_ready=0 -> 0x01..0x04 retained, overrun=1. Draining yields 0x01,0x02,0x03,0x04, then rx_valid=0; pointer wrap is verified by a subsequent 6-byte stream.
